// File: rtl/weight_bank_pkg.sv
// Shared definitions for the weight bank: controller states, LFSR constants
// and a helper for locating a lane inside a packed multi-lane bus.
package weight_bank_pkg;

  // IDLE : bank never filled (or fill aborted by reset), accesses allowed
  // INIT : LFSR fill in progress, all accesses ignored
  // READY: bank holds a complete fill, accesses allowed
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Low bit position of lane k in a bus of w-bit lanes.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/weight_lfsr.sv
// Galois right-shift LFSR used to generate pseudo-random weights.
// Ports:
//   Clock - rising-edge clock
//   Rst   - synchronous active-high reset, loads the (guarded) seed
//   en    - advance one step this cycle
//   seed  - reset value; zero is replaced by 1 so the register never locks up
//   value - current LFSR state
module weight_lfsr
  import weight_bank_pkg::*;
#(
  parameter int LFSR_W = 16
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] POLY = LFSR_W'(LFSR_POLY);

  logic [LFSR_W-1:0] seed_safe;

  assign seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

  always_ff @(posedge Clock) begin
    if (Rst) begin
      value <= seed_safe;
    end else if (en) begin
      value <= (value >> 1) ^ (value[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/weight_bank_lfsr.sv
// Multi-lane weight memory with a built-in LFSR bank fill.
// Ports:
//   Clock, Rst   - rising-edge clock, synchronous active-high reset
//   init_start   - request a full-bank fill from the LFSR (ignored during a fill)
//   init_busy    - high while the fill runs (exactly DEPTH cycles)
//   init_done    - high while the bank holds a completed fill
//   addr         - base word address; lanes cover addr..addr+LANES-1 mod DEPTH
//   rd_en, we    - read / write request (outside a fill)
//   wr_data      - write lanes, lane k at [k*WIDTH +: WIDTH]
//   rd_data      - read lanes, same packing, held between reads
//   rd_valid     - one-cycle pulse, the cycle after an accepted read
//   state_dbg    - controller state for observation
// Handshake: there is no back-pressure. A request is accepted on any rising
// edge where the bank is not filling and init_start is low; an accepted read
// always completes with rd_valid on the very next edge.
module weight_bank_lfsr
  import weight_bank_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int LANES  = 10,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(DEFAULT_SEED)
) (
  input  logic                   Clock,
  input  logic                   Rst,
  input  logic                   init_start,
  output logic                   init_busy,
  output logic                   init_done,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   rd_en,
  input  logic                   we,
  input  logic [LANES*WIDTH-1:0] wr_data,
  output logic [LANES*WIDTH-1:0] rd_data,
  output logic                   rd_valid,
  output state_t                 state_dbg
);

  state_t state, state_nx;

  logic signed [WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W-1:0]      cnt;
  logic                   fill_last;
  logic                   lfsr_en;
  logic [LFSR_W-1:0]      lfsr_val;
  logic                   unused_lfsr_bits;
  logic                   start_ok;
  logic                   access_ok;
  logic                   addr_ok;
  logic [ADDR_W-1:0]      word_idx [LANES];
  logic [ADDR_W:0]        idx_sum;
  logic [LANES*WIDTH-1:0] rd_next;

  weight_lfsr #(
    .LFSR_W (LFSR_W)
  ) u_lfsr (
    .Clock (Clock),
    .Rst   (Rst),
    .en    (lfsr_en),
    .seed  (SEED),
    .value (lfsr_val)
  );

  // Only the low WIDTH bits become weights.
  assign unused_lfsr_bits = ^lfsr_val;

  // init_start outranks a same-cycle access; nothing is accepted mid-fill.
  assign start_ok  = (state != INIT) && init_start;
  assign access_ok = (state != INIT) && !init_start;
  assign fill_last = (cnt == ADDR_W'(DEPTH - 1));
  assign addr_ok   = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign state_dbg = state;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, READY: if (init_start) state_nx = INIT;
      INIT:        if (fill_last)  state_nx = READY;
      default:     state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // READY is only left through an accepted init_start or reset, so "done"
  // coincides with being in READY.
  always_comb begin
    init_busy = (state == INIT);
    init_done = (state == READY);
    lfsr_en   = (state == INIT);
  end

  // Fill counter: one word per cycle while filling.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      cnt <= '0;
    end else if (start_ok) begin
      cnt <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  // Lane word indices, wrapped modulo DEPTH. The sum is one bit wider than
  // the address so addr + k cannot overflow before the wrap.
  always_comb begin
    idx_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      idx_sum = {1'b0, addr} + (ADDR_W + 1)'(k);
      if (idx_sum >= (ADDR_W + 1)'(DEPTH)) begin
        idx_sum = idx_sum - (ADDR_W + 1)'(DEPTH);
      end
      word_idx[k] = idx_sum[ADDR_W-1:0];
    end
  end

  // Out-of-range base addresses read as zero.
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < LANES; k++) begin
      if (addr_ok) begin
        rd_next[lane_lo(k, WIDTH) +: WIDTH] = mem[word_idx[k]];
      end
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      if (state == INIT) begin
        mem[cnt] <= lfsr_val[WIDTH-1:0];
      end else if (access_ok && we && addr_ok) begin
        for (int k = 0; k < LANES; k++) begin
          mem[word_idx[k]] <= wr_data[lane_lo(k, WIDTH) +: WIDTH];
        end
      end
    end
  end

  // rd_next is sampled from the pre-edge array, so a same-cycle write is
  // not visible to the read (read-before-write).
  always_ff @(posedge Clock) begin
    if (Rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= access_ok && rd_en;
      if (access_ok && rd_en) begin
        rd_data <= rd_next;
      end
    end
  end

endmodule

// File: tb/tb_weight_bank_lfsr.sv
module tb_weight_bank_lfsr;
  import weight_bank_pkg::*;

  localparam int W = 10;
  localparam int L = 10;
  localparam int D = 128;
  localparam int AW = 7;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic           Rst = 1'b1;
  logic           init_start = 1'b0;
  logic           init_busy, init_done;
  logic [AW-1:0]  addr = '0;
  logic           rd_en = 1'b0;
  logic           we = 1'b0;
  logic [L*W-1:0] wr_data = '0;
  logic [L*W-1:0] rd_data;
  logic           rd_valid;
  state_t         state_dbg;

  weight_bank_lfsr dut (
    .Clock      (Clock),
    .Rst        (Rst),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .addr       (addr),
    .rd_en      (rd_en),
    .we         (we),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .state_dbg  (state_dbg)
  );

  // ---------------- reference model ----------------
  logic [15:0]  seq [$];      // LFSR state after i steps from the seed
  logic [W-1:0] mem_m [D];
  int           lfsr_pos = 0; // steps taken since the last reset
  int           total = 0;
  int           bad = 0;

  function automatic logic [W-1:0] lane(input logic [L*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  function automatic logic [W-1:0] model_word(input int a, input int k);
    return mem_m[(a + k) % D];
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_lanes(input string tag, input int a);
    for (int k = 0; k < L; k++) begin
      chk($sformatf("%s_lane%0d", tag, k), 64'(lane(rd_data, k)), 64'(model_word(a, k)));
    end
  endtask

  task automatic do_read(input string tag, input int a);
    addr  = AW'(a);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    check_lanes(tag, a);
  endtask

  task automatic do_write(input int a, input logic [L*W-1:0] d);
    addr    = AW'(a);
    wr_data = d;
    we      = 1'b1;
    tick();
    we = 1'b0;
    for (int k = 0; k < L; k++) mem_m[(a + k) % D] = d[k*W +: W];
  endtask

  function automatic logic [L*W-1:0] rand_data();
    logic [L*W-1:0] d;
    for (int k = 0; k < L; k++) d[k*W +: W] = W'($urandom_range(0, (1 << W) - 1));
    return d;
  endfunction

  // Full fill; when noisy, random reads/writes are thrown at the bank the
  // whole time and must have no visible effect.
  task automatic run_fill(input string tag, input bit noisy);
    int n;
    logic [L*W-1:0] held;
    held       = rd_data;
    init_start = 1'b1;
    if (noisy) begin
      rd_en = 1'b1; we = 1'b1; addr = AW'($urandom_range(0, D - 1)); wr_data = rand_data();
    end
    tick();
    init_start = 1'b0;
    chk({tag, "_start_busy"}, 64'(init_busy), 64'd1);
    chk({tag, "_start_done_low"}, 64'(init_done), 64'd0);
    chk({tag, "_start_drops_read"}, 64'(rd_valid), 64'd0);
    n = 0;
    while (init_busy && n < 300) begin
      if (noisy) begin
        rd_en = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        init_start = 1'($urandom_range(0, 1));
        addr = AW'($urandom_range(0, D - 1)); wr_data = rand_data();
      end
      tick();
      n++;
      if (noisy) begin
        chk({tag, "_no_valid_in_init"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_data_held"}, 64'(rd_data ^ held), 64'd0);
      end
    end
    rd_en = 1'b0; we = 1'b0; init_start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'(D));
    chk({tag, "_done"}, 64'(init_done), 64'd1);
    chk({tag, "_state_ready"}, 64'(state_dbg), 64'(READY));
    for (int i = 0; i < D; i++) mem_m[i] = seq[lfsr_pos + i][W-1:0];
    lfsr_pos += D;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0]    s;
    logic [L*W-1:0] d, held;
    logic [W-1:0]   old_m [L];
    int             a, r;

    s = 16'hACE1;
    for (int i = 0; i < 600; i++) begin
      seq.push_back(s);
      s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    end

    // Reset
    repeat (3) tick();
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_busy", 64'(init_busy), 64'd0);
    chk("rst_done", 64'(init_done), 64'd0);
    chk("rst_rd_data", 64'(rd_data == '0), 64'd1);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    Rst = 1'b0;
    tick();

    // 1: first fill, first words are the seed sequence
    run_fill("fill1", 1'b0);
    do_read("rd0_fill1", 0);
    chk("w0_const", 64'(lane(rd_data, 0)), 64'h0E1);
    chk("w1_const", 64'(lane(rd_data, 1)), 64'h270);
    chk("w2_const", 64'(lane(rd_data, 2)), 64'h138);
    chk("w3_const", 64'(lane(rd_data, 3)), 64'h09C);

    // 2: back-to-back reads, each result one cycle after its request
    for (int i = 0; i < 5; i++) begin
      addr  = AW'(i * 10);
      rd_en = 1'b1;
      tick();
      chk($sformatf("b2b%0d_valid", i), 64'(rd_valid), 64'd1);
      check_lanes($sformatf("b2b%0d", i), i * 10);
    end
    rd_en = 1'b0;
    tick();
    chk("b2b_valid_drops", 64'(rd_valid), 64'd0);
    check_lanes("b2b_hold", 40);

    // 3: write wrapping past the end of the bank
    for (int k = 0; k < L; k++) d[k*W +: W] = W'(k + 1);
    do_write(120, d);
    do_read("rd120", 120);
    chk("rd120_lane7", 64'(lane(rd_data, 7)), 64'd8);
    do_read("rd0_wrap", 0);
    chk("wrap_lane0", 64'(lane(rd_data, 0)), 64'd9);
    chk("wrap_lane1", 64'(lane(rd_data, 1)), 64'd10);

    // 4: same-cycle read and write return the old contents
    d = rand_data();
    for (int k = 0; k < L; k++) old_m[k] = model_word(50, k);
    addr = AW'(50); wr_data = d; we = 1'b1; rd_en = 1'b1;
    tick();
    we = 1'b0; rd_en = 1'b0;
    chk("rbw_valid", 64'(rd_valid), 64'd1);
    for (int k = 0; k < L; k++)
      chk($sformatf("rbw_old_lane%0d", k), 64'(lane(rd_data, k)), 64'(old_m[k]));
    for (int k = 0; k < L; k++) mem_m[(50 + k) % D] = d[k*W +: W];
    do_read("rbw_new", 50);

    // Randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      a = (i % 4 == 0) ? $urandom_range(D - L, D - 1) : $urandom_range(0, D - 1);
      r = $urandom_range(0, 2);
      d = rand_data();
      held = rd_data;
      for (int k = 0; k < L; k++) old_m[k] = model_word(a, k);
      addr = AW'(a); wr_data = d; rd_en = (r != 1); we = (r != 0);
      tick();
      rd_en = 1'b0; we = 1'b0;
      chk($sformatf("rnd%0d_valid", i), 64'(rd_valid), 64'(r != 1));
      if (r != 1) begin
        for (int k = 0; k < L; k++)
          chk($sformatf("rnd%0d_lane%0d", i, k), 64'(lane(rd_data, k)), 64'(old_m[k]));
      end else begin
        chk($sformatf("rnd%0d_hold", i), 64'(rd_data ^ held), 64'd0);
      end
      if (r != 0) for (int k = 0; k < L; k++) mem_m[(a + k) % D] = d[k*W +: W];
    end
    do_read("rnd_final", 0);

    // 6: second fill continues the LFSR sequence, accesses ignored meanwhile
    run_fill("fill2", 1'b1);
    do_read("rd0_fill2", 0);
    chk("fill2_w0_step128", 64'(lane(rd_data, 0)), 64'(seq[128][W-1:0]));
    do_read("rd64_fill2", 64);

    // 5: reset in the middle of a fill
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (60) tick();
    for (int i = 0; i < 60; i++) mem_m[i] = seq[lfsr_pos + i][W-1:0];
    Rst = 1'b1;
    tick();
    chk("midrst_busy", 64'(init_busy), 64'd0);
    chk("midrst_done", 64'(init_done), 64'd0);
    chk("midrst_state", 64'(state_dbg), 64'(IDLE));
    tick();
    Rst = 1'b0;
    lfsr_pos = 0;
    tick();
    do_read("partial_lo", 50);
    do_read("partial_hi", 100);
    run_fill("fill3", 1'b0);
    do_read("rd0_fill3", 0);
    chk("fill3_w0_seed", 64'(lane(rd_data, 0)), 64'h0E1);
    do_read("rd118_fill3", 118);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
